// File: rtl/nios2_onchip_mem_pipe.sv
// rtl/nios2_onchip_mem_pipe.sv - Avalon-MM pipelined byte-enabled on-chip RAM slave with optional zero-fill
// Optional feature macro: NIOS2_OCM_RDW_BYPASS_EN (read merges the write accepted in the previous cycle)
module nios2_onchip_mem_pipe #(
    parameter int    DATA_W         = 32,
    parameter int    DEPTH          = 5120,
    parameter int    ADDR_W         = 13,
    parameter int    READ_LATENCY   = 1,
    parameter string INIT_FILE      = "nios2_onchip_mem.hex",
    parameter bit    CLEAR_ON_RESET = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W/8-1:0]   byteenable,
    input  logic                  chipselect,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_W-1:0]     writedata,
    input  logic                  clken,
    input  logic                  reset_req,
    output logic [DATA_W-1:0]     readdata,
    output logic                  readdatavalid,
    output logic                  waitrequest,
    output logic                  init_done
);
    localparam int              BE_W     = DATA_W / 8;
    localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LP_LAST = IDX_W'(DEPTH - 1);
    localparam logic [0:0]      ST_CLEAR = 1'b0;
    localparam logic [0:0]      ST_READY = 1'b1;
    localparam logic [0:0]      ST_RESET = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [0:0]        r_state;
    logic [IDX_W-1:0]  r_clr_cnt;

    logic              w_in_range;
    logic              w_acc;
    logic              w_acc_rd;
    logic              w_acc_wr;
    logic              w_clr_we;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_rd_data;

    assign waitrequest = ~reset_n | (r_state != ST_READY) | ~clken | reset_req;
    assign init_done   = (r_state == ST_READY);
    assign w_in_range  = ({1'b0, address} < LP_DEPTH);
    assign w_idx       = address[IDX_W-1:0];
    assign w_acc       = chipselect & (read | write) & ~waitrequest;
    // A simultaneous read+write is served as a write only.
    assign w_acc_wr    = w_acc & write & w_in_range;
    assign w_acc_rd    = w_acc & read & ~write;
    assign w_clr_we    = (r_state == ST_CLEAR) & clken;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_RESET;
            r_clr_cnt <= '0;
        end else if (clken && r_state == ST_CLEAR) begin
            if (r_clr_cnt == LP_LAST) begin
                r_state <= ST_READY;
            end
            r_clr_cnt <= r_clr_cnt + 1'b1;
        end
    end

    // Array contents survive reset, so this block has no reset branch.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_acc_wr) begin
            for (int b = 0; b < BE_W; b++) begin
                if (byteenable[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= writedata[b*8 +: 8];
                end
            end
        end
    end

`ifdef NIOS2_OCM_RDW_BYPASS_EN
    logic              r_lw_vld;
    logic [ADDR_W-1:0] r_lw_addr;
    logic [BE_W-1:0]   r_lw_be;
    logic [DATA_W-1:0] r_lw_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lw_vld  <= 1'b0;
            r_lw_addr <= '0;
            r_lw_be   <= '0;
            r_lw_data <= '0;
        end else if (clken) begin
            r_lw_vld <= w_acc_wr;
            if (w_acc_wr) begin
                r_lw_addr <= address;
                r_lw_be   <= byteenable;
                r_lw_data <= writedata;
            end
        end
    end

    always_comb begin
        w_rd_data = w_in_range ? r_mem[w_idx] : '0;
        if (r_lw_vld && w_in_range && r_lw_addr == address) begin
            for (int b = 0; b < BE_W; b++) begin
                if (r_lw_be[b]) begin
                    w_rd_data[b*8 +: 8] = r_lw_data[b*8 +: 8];
                end
            end
        end
    end
`else
    assign w_rd_data = w_in_range ? r_mem[w_idx] : '0;
`endif

    // readdata only moves when a result retires, so it holds between pulses.
    generate
        if (READ_LATENCY == 1) begin : g_lat1
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    readdatavalid <= 1'b0;
                    readdata      <= '0;
                end else if (clken) begin
                    readdatavalid <= w_acc_rd;
                    if (w_acc_rd) begin
                        readdata <= w_rd_data;
                    end
                end
            end
        end else begin : g_lat2
            logic              r_s1_vld;
            logic [DATA_W-1:0] r_s1_data;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_s1_vld      <= 1'b0;
                    r_s1_data     <= '0;
                    readdatavalid <= 1'b0;
                    readdata      <= '0;
                end else if (clken) begin
                    r_s1_vld <= w_acc_rd;
                    if (w_acc_rd) begin
                        r_s1_data <= w_rd_data;
                    end
                    readdatavalid <= r_s1_vld;
                    if (r_s1_vld) begin
                        readdata <= r_s1_data;
                    end
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_nios2_onchip_mem_pipe.sv
// tb/tb_nios2_onchip_mem_pipe.sv - self-checking bench for nios2_onchip_mem_pipe
// Instance a: latency 1, no clear; instance b: latency 2, zero-fill after reset.
module tb_nios2_onchip_mem_pipe;
    localparam int D = 20;
    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    logic        clk;
    logic        reset_n, chipselect, read, write, clken, reset_req;
    logic [5:0]  address;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] rdata [2];
    logic [1:0]  rdv, wreq, done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    nios2_onchip_mem_pipe #(.DATA_W(32), .DEPTH(D), .ADDR_W(6), .READ_LATENCY(1),
                            .INIT_FILE(""), .CLEAR_ON_RESET(1'b0)) u_a (
        .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .clken(clken), .reset_req(reset_req), .readdata(rdata[0]),
        .readdatavalid(rdv[0]), .waitrequest(wreq[0]), .init_done(done[0]));

    nios2_onchip_mem_pipe #(.DATA_W(32), .DEPTH(D), .ADDR_W(6), .READ_LATENCY(2),
                            .INIT_FILE(""), .CLEAR_ON_RESET(1'b1)) u_b (
        .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .clken(clken), .reset_req(reset_req), .readdata(rdata[1]),
        .readdatavalid(rdv[1]), .waitrequest(wreq[1]), .init_done(done[1]));

    int n_chk = 0;
    int n_err = 0;

    // Reference model: word array per instance plus a list of outstanding reads
    // that retire after LATENCY enabled edges.
    typedef struct { int inst; logic [31:0] d; bit k; int left; } pend_t;
    logic [31:0] m_mem   [2][D];
    bit          m_known [2][D];
    bit          m_ready [2];
    int          m_clr   [2];
    bit          e_rdv   [2];
    logic [31:0] e_rd    [2];
    bit          e_rdk   [2];
    pend_t       m_q[$];

    typedef struct {
        bit cs, rd, wr, ce, rq;
        logic [5:0]  a;
        logic [3:0]  be;
        logic [31:0] wd;
        bit ew, ev, ck;
        logic [31:0] er;
    } vec_t;
    vec_t tbl[12];

    function automatic logic [31:0] init_val(input int w);
        return 32'h5A00_0000 ^ (32'h0101_0101 * 32'(w));
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%b expected=%b t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int i);
        for (int j = m_q.size() - 1; j >= 0; j--) begin
            if (m_q[j].inst == i) m_q.delete(j);
        end
        e_rdv[i]   = 1'b0;
        e_rd[i]    = 32'h0;
        e_rdk[i]   = 1'b1;
        m_ready[i] = (i == 0);
        m_clr[i]   = D;
    endtask

    task automatic model_edge(input int i);
        pend_t p;
        if (!reset_n) begin
            model_reset(i);
            return;
        end
        if (!clken) return;
        if (!m_ready[i]) begin
            m_clr[i]--;
            if (m_clr[i] == 0) begin
                m_ready[i] = 1'b1;
                for (int w = 0; w < D; w++) begin
                    m_mem[i][w]   = 32'h0;
                    m_known[i][w] = 1'b1;
                end
            end
            return;
        end
        if (!reset_req && chipselect && (read || write)) begin
            if (write) begin
                if (int'(address) < D) begin
                    for (int b = 0; b < 4; b++) begin
                        if (byteenable[b]) m_mem[i][address][b*8 +: 8] = writedata[b*8 +: 8];
                    end
                end
            end else begin
                p.inst = i;
                p.left = (i == 0) ? 1 : 2;
                if (int'(address) < D) begin
                    p.d = m_mem[i][address];
                    p.k = m_known[i][address];
                end else begin
                    p.d = 32'h0;
                    p.k = 1'b1;
                end
                m_q.push_back(p);
            end
        end
        e_rdv[i] = 1'b0;
        for (int j = m_q.size() - 1; j >= 0; j--) begin
            if (m_q[j].inst == i) begin
                m_q[j].left = m_q[j].left - 1;
                if (m_q[j].left == 0) begin
                    e_rdv[i] = 1'b1;
                    e_rd[i]  = m_q[j].d;
                    e_rdk[i] = m_q[j].k;
                    m_q.delete(j);
                end
            end
        end
    endtask

    task automatic cycle();
        #2;
        for (int i = 0; i < 2; i++) begin
            chk1($sformatf("wait%0d", i), wreq[i], !reset_n || !m_ready[i] || !clken || reset_req);
        end
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk1($sformatf("rdv%0d", i), rdv[i], e_rdv[i]);
            chk1($sformatf("done%0d", i), done[i], m_ready[i]);
            if (e_rdk[i]) chk32($sformatf("rdata%0d", i), rdata[i], e_rd[i]);
        end
    endtask

    task automatic setin(input bit cs, input bit rd, input bit wr, input logic [5:0] a,
                         input logic [3:0] be, input logic [31:0] wd, input bit ce, input bit rq);
        chipselect = cs;
        read       = rd;
        write      = wr;
        address    = a;
        byteenable = be;
        writedata  = wd;
        clken      = ce;
        reset_req  = rq;
    endtask

    task automatic idle(input int n);
        setin(L, L, L, 6'd0, 4'h0, 32'h0, H, L);
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int          en_cnt;
        int          nrd;
        int          pulses;
        logic [6:0]  pat_a, pat_b;

        tbl[0]  = '{H, L, H, H, L, 6'd8,  4'hF, 32'hFFFF_FFFF, L, L, L, 32'h0};
        tbl[1]  = '{H, L, H, H, L, 6'd8,  4'h5, 32'h1122_3344, L, L, L, 32'h0};
        tbl[2]  = '{H, H, L, H, L, 6'd8,  4'h0, 32'h0,         L, H, H, 32'hFF22_FF44};
        tbl[3]  = '{H, H, L, H, L, 6'd20, 4'h0, 32'h0,         L, H, H, 32'h0};
        tbl[4]  = '{H, H, H, H, L, 6'd5,  4'hF, 32'hA5A5_A5A5, L, L, H, 32'h0};
        tbl[5]  = '{H, H, L, H, L, 6'd5,  4'h0, 32'h0,         L, H, H, 32'hA5A5_A5A5};
        tbl[6]  = '{H, H, L, H, H, 6'd5,  4'h0, 32'h0,         H, L, H, 32'hA5A5_A5A5};
        tbl[7]  = '{L, H, L, H, L, 6'd8,  4'h0, 32'h0,         L, L, H, 32'hA5A5_A5A5};
        tbl[8]  = '{H, H, L, L, L, 6'd8,  4'h0, 32'h0,         H, L, H, 32'hA5A5_A5A5};
        tbl[9]  = '{H, L, H, H, L, 6'd21, 4'hF, 32'h0,         L, L, H, 32'hA5A5_A5A5};
        tbl[10] = '{H, H, L, H, L, 6'd21, 4'h0, 32'h0,         L, H, H, 32'h0};
        tbl[11] = '{H, H, L, H, L, 6'd8,  4'h0, 32'h0,         L, H, H, 32'hFF22_FF44};

        model_reset(0);
        model_reset(1);
        reset_n = 1'b0;
        setin(L, L, L, 6'd0, 4'h0, 32'h0, H, L);
        cycle();
        cycle();
        chk1("rst_rdv_b", rdv[1], 1'b0);
        chk1("rst_done_b", done[1], 1'b0);
        chk1("rst_done_a", done[0], 1'b1);
        chk1("rst_wait_a", wreq[0], 1'b1);
        chk32("rst_rdata_a", rdata[0], 32'h0);

        // Zero-fill must take exactly DEPTH enabled cycles, disabled ones not counted.
        reset_n = 1'b1;
        en_cnt  = 0;
        for (int k = 0; k < 80 && !done[1]; k++) begin
            clken = (k % 4 != 3);
            cycle();
            if (clken) en_cnt++;
        end
        chk32("t4_clear_cycles", 32'(en_cnt), 32'd20);

        for (int w = 0; w < D; w++) begin
            setin(H, L, H, 6'(w), 4'hF, init_val(w), H, L);
            cycle();
        end
        idle(2);

        foreach (tbl[j]) begin
            setin(tbl[j].cs, tbl[j].rd, tbl[j].wr, tbl[j].a, tbl[j].be, tbl[j].wd, tbl[j].ce, tbl[j].rq);
            #2;
            chk1($sformatf("tbl%0d_wait", j), wreq[0], tbl[j].ew);
            cycle();
            chk1($sformatf("tbl%0d_rdv", j), rdv[0], tbl[j].ev);
            if (tbl[j].ck) chk32($sformatf("tbl%0d_rdata", j), rdata[0], tbl[j].er);
        end

        // Back-to-back reads on the latency-2 instance.
        idle(2);
        pat_b = '0;
        nrd   = 0;
        for (int k = 0; k < 7; k++) begin
            if (k < 4) setin(H, H, L, 6'(k), 4'h0, 32'h0, H, L);
            else       setin(L, L, L, 6'd0, 4'h0, 32'h0, H, L);
            cycle();
            pat_b[k] = rdv[1];
            if (rdv[1]) begin
                chk32($sformatf("t3_data%0d", nrd), rdata[1], init_val(nrd));
                nrd++;
            end
        end
        chk32("t3_pattern", 32'(pat_b), 32'h1E);

        // Three frozen cycles right after a read accept.
        idle(2);
        pat_a = '0;
        pat_b = '0;
        for (int k = 0; k < 6; k++) begin
            if (k == 0) setin(H, H, L, 6'd2, 4'h0, 32'h0, H, L);
            else        setin(L, L, L, 6'd0, 4'h0, 32'h0, (k < 1 || k > 3), L);
            cycle();
            pat_a[k] = rdv[0];
            pat_b[k] = rdv[1];
        end
        chk32("t5_stall_b", 32'(pat_b), 32'h10);
        chk32("t5_stall_a", 32'(pat_a), 32'h0F);

        // Reset with reads still in flight.
        idle(2);
        setin(H, H, L, 6'd3, 4'h0, 32'h0, H, L);
        cycle();
        setin(H, H, L, 6'd4, 4'h0, 32'h0, H, L);
        cycle();
        reset_n = 1'b0;
        idle(2);
        chk32("t5_rst_rdata_b", rdata[1], 32'h0);
        reset_n = 1'b1;
        pulses  = 0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            pulses += int'(rdv[1]) + int'(rdv[0]);
        end
        chk32("t5_rst_pulses", 32'(pulses), 32'd0);
        for (int k = 0; k < 60 && !done[1]; k++) cycle();
        chk1("t5_b_ready_again", done[1], 1'b1);

        for (int k = 0; k < 600; k++) begin
            setin($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0,
                  6'($urandom_range(0, 23)), 4'($urandom), $urandom,
                  $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0);
            cycle();
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
